// File: rtl/fmap_pkg.sv
// Shared feature-map tile definitions used by both the tile writer and the
// display tile readers, so both ends agree on the word packing.
package fmap_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FILL  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t DONE  = 2'd3;

  function automatic int pix_per_word(input int word_bits, input int pix_bits);
    return word_bits / pix_bits;
  endfunction

endpackage

// File: rtl/pixel_word_packer.sv
// Slot-indexed pixel packer: pixel k of a word lands at bits [k*PIX_BITS +: PIX_BITS].
// word_next already includes the pixel being shifted in this cycle.
module pixel_word_packer #(
  parameter int PIX_BITS = 8,
  parameter int PPW      = 32,
  localparam int SLOT_W  = (PPW > 1) ? $clog2(PPW) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    shift,
  input  logic [PIX_BITS-1:0]     pixel,
  output logic [PPW*PIX_BITS-1:0] word_next,
  output logic                    full
);

  logic [PPW*PIX_BITS-1:0] word;
  logic [SLOT_W-1:0]       slot;

  always_comb begin
    word_next = word;
    if (shift) word_next[slot*PIX_BITS +: PIX_BITS] = pixel;
  end

  // True when the next shifted pixel occupies the final slot of the word.
  assign full = (slot == SLOT_W'(PPW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      slot <= '0;
    end else if (clear) begin
      word <= '0;
      slot <= '0;
    end else if (shift) begin
      word <= word_next;
      slot <= slot + 1'b1;
    end
  end

endmodule

// File: rtl/fmap_tile_writer.sv
// Packs a raster-order pixel stream for one feature-map tile into BRAM words
// and writes them to port A starting at BASE_ADDR.
module fmap_tile_writer
  import fmap_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 'h000,
  parameter int          TILE_W    = 24,
  parameter int          TILE_H    = 24,
  parameter int          WORD_BITS = 256,
  parameter int          PIX_BITS  = 8,
  parameter int          ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_BITS-1:0]  in_pixel,
  input  logic                 in_last,
  output logic                 bram_we,
  output logic [ADDR_BITS-1:0] bram_addr,
  output logic [WORD_BITS-1:0] bram_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 last_err
);

  localparam int PPW        = pix_per_word(WORD_BITS, PIX_BITS);
  localparam int NPIX       = TILE_W * TILE_H;
  localparam int NWORDS     = (NPIX + PPW - 1) / PPW;
  localparam int PIX_CNT_W  = $clog2(NPIX + 1);
  localparam int WORD_CNT_W = $clog2(NWORDS + 1);

  if (WORD_BITS % PIX_BITS != 0) begin : g_bad_packing
    $error("fmap_tile_writer: WORD_BITS must be a multiple of PIX_BITS");
  end
  if (longint'(BASE_ADDR) + longint'(NWORDS) > (longint'(1) << ADDR_BITS)) begin : g_bad_range
    $error("fmap_tile_writer: tile would wrap the BRAM address space");
  end

  state_t                 state;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [WORD_CNT_W-1:0]  word_idx;
  logic                   finish;
  logic                   accept;
  logic                   final_pix;
  logic                   word_done;
  logic                   packer_clear;
  logic                   full;
  logic [WORD_BITS-1:0]   word_next;

  assign accept       = (state == FILL) && in_valid;
  assign final_pix    = (pix_cnt == PIX_CNT_W'(NPIX - 1));
  assign word_done    = accept && (full || final_pix || in_last);
  assign packer_clear = ((state == IDLE) && start) || (state == WRITE);

  assign in_ready = (state == FILL);
  assign bram_we  = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  pixel_word_packer #(
    .PIX_BITS (PIX_BITS),
    .PPW      (PPW)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (packer_clear),
    .shift     (accept),
    .pixel     (in_pixel),
    .word_next (word_next),
    .full      (full)
  );

  // Address and data are registered on the completing handshake so they
  // hold steady through the write strobe and between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      word_idx   <= '0;
      finish     <= 1'b0;
      last_err   <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            pix_cnt  <= '0;
            word_idx <= '0;
            finish   <= 1'b0;
            last_err <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (in_last != final_pix) last_err <= 1'b1;
            if (word_done) begin
              state      <= WRITE;
              finish     <= final_pix || in_last;
              bram_addr  <= ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(word_idx);
              bram_wdata <= word_next;
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 1'b1;
          state    <= finish ? DONE : FILL;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_tile_writer.sv
// Scoreboard bench for fmap_tile_writer: a default 24x24 tile instance and a
// 5x5 tile instance at BASE_ADDR 0x100.
module tb_fmap_tile_writer;

  typedef struct packed {
    logic [11:0]  addr;
    logic [255:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_a, in_valid_a, in_ready_a, in_last_a;
  logic [7:0]   in_pixel_a;
  logic         bram_we_a, busy_a, done_a, last_err_a;
  logic [11:0]  bram_addr_a;
  logic [255:0] bram_wdata_a;

  logic         start_b, in_valid_b, in_ready_b, in_last_b;
  logic [7:0]   in_pixel_b;
  logic         bram_we_b, busy_b, done_b, last_err_b;
  logic [11:0]  bram_addr_b;
  logic [255:0] bram_wdata_b;

  wr_t  exp_a[$];
  wr_t  exp_b[$];
  logic exp_err_a[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_we_a = 1'b0;

  fmap_tile_writer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pixel(in_pixel_a), .in_last(in_last_a), .bram_we(bram_we_a), .bram_addr(bram_addr_a),
    .bram_wdata(bram_wdata_a), .busy(busy_a), .done(done_a), .last_err(last_err_a)
  );

  fmap_tile_writer #(.BASE_ADDR('h100), .TILE_W(5), .TILE_H(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pixel(in_pixel_b), .in_last(in_last_b), .bram_we(bram_we_b), .bram_addr(bram_addr_b),
    .bram_wdata(bram_wdata_b), .busy(busy_b), .done(done_b), .last_err(last_err_b)
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected word w of a default tile whose pixel i is i[7:0], ending after n_end pixels.
  function automatic logic [255:0] expWord(input int w, input int n_end);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 32; k++) begin
      int idx;
      idx = w * 32 + k;
      if (idx < n_end) d[k*8 +: 8] = 8'(idx);
    end
    return d;
  endfunction

  task automatic pushTile(input int n_end, input logic err);
    for (int w = 0; w < (n_end + 31) / 32; w++)
      exp_a.push_back('{addr: 12'(w), data: expWord(w, n_end)});
    exp_err_a.push_back(err);
  endtask

  always @(negedge clk) begin
    wr_t  e;
    logic ee;
    if (bram_we_a) begin
      checkOutput("a_ready_low_in_write", in_ready_a, 0);
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL a_unexpected_write addr=%0h expected=no_write", bram_addr_a);
      end else begin
        e = exp_a.pop_front();
        checkOutput("a_wr_addr", bram_addr_a, e.addr);
        checkOutput("a_wr_data", bram_wdata_a, e.data);
      end
    end
    if (done_a) begin
      checkOutput("a_done_after_last_write", prev_we_a, 1);
      if (exp_err_a.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL a_unexpected_done actual=1 expected=0");
      end else begin
        ee = exp_err_a.pop_front();
        checkOutput("a_last_err_at_done", last_err_a, ee);
      end
    end
    prev_we_a = bram_we_a;
  end

  always @(negedge clk) begin
    wr_t e;
    if (bram_we_b) begin
      checkOutput("b_ready_low_in_write", in_ready_b, 0);
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL b_unexpected_write addr=%0h expected=no_write", bram_addr_b);
      end else begin
        e = exp_b.pop_front();
        checkOutput("b_wr_addr", bram_addr_b, e.addr);
        checkOutput("b_wr_data", bram_wdata_b, e.data);
      end
    end
  end

  task automatic drivePixel(input int sel, input logic v, input logic [7:0] p, input logic l);
    if (sel == 0) begin in_valid_a = v; in_pixel_a = p; in_last_a = l; end
    else begin in_valid_b = v; in_pixel_b = p; in_last_b = l; end
  endtask

  // Presents one pixel and waits (bounded) for its handshake.
  task automatic applyStimulus(input int sel, input logic [7:0] pix, input logic last, input bit gaps);
    logic hs;
    if (gaps && ($urandom_range(1, 0) == 1)) begin
      drivePixel(sel, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
    end
    drivePixel(sel, 1'b1, pix, last);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      hs = (sel == 0) ? in_ready_a : in_ready_b;
      @(posedge clk); #1;
      if (hs) return;
    end
    checks++; errors++;
    $display("[TB] FAIL handshake_timeout pixel=%0h expected=accepted", pix);
  endtask

  task automatic sendTile(input int n, input int last_at, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (i == start_at) start_a = 1'b1;
      applyStimulus(0, 8'(i), i == last_at, gaps);
      start_a = 1'b0;
    end
    drivePixel(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic startTile(input int sel);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Returns at the falling edge of the DONE cycle.
  task automatic waitDone(input int sel);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ((sel == 0) ? done_a : done_b) return;
    end
    checks++; errors++;
    $display("[TB] FAIL done_timeout actual=0 expected=1");
  endtask

  task automatic finishTile(input string name);
    waitDone(0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, "_busy_low_after_done"}, busy_a, 0);
    checkOutput({name, "_all_writes_seen"}, exp_a.size(), 0);
    checkOutput({name, "_done_seen"}, exp_err_a.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_busy"}, busy_a, 0);
    checkOutput({name, "_done"}, done_a, 0);
    checkOutput({name, "_ready"}, in_ready_a, 0);
    checkOutput({name, "_we"}, bram_we_a, 0);
    checkOutput({name, "_last_err"}, last_err_a, 0);
    checkOutput({name, "_addr"}, bram_addr_a, 0);
    checkOutput({name, "_wdata"}, bram_wdata_a, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    drivePixel(0, 1'b0, 8'h00, 1'b0);
    drivePixel(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 5x5 tile: a single zero-padded word at 0x100
    exp_b.push_back('{addr: 12'h100,
      data: 256'h00000000000000_b8b7b6b5b4b3b2b1b0afaeadacabaaa9a8a7a6a5a4a3a2a1a0});
    startTile(1);
    for (int i = 0; i < 25; i++) applyStimulus(1, 8'(8'hA0 + i), i == 24, 1'b0);
    drivePixel(1, 1'b0, 8'h00, 1'b0);
    waitDone(1);
    checkOutput("b_last_err", last_err_b, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b_busy_low_after_done", busy_b, 0);
    checkOutput("b_all_writes_seen", exp_b.size(), 0);
    @(posedge clk); #1;

    // full tile, continuous valid
    pushTile(576, 1'b0);
    startTile(0);
    sendTile(576, 575, 1'b0, -1);
    finishTile("full");

    // full tile with random valid gaps
    pushTile(576, 1'b0);
    startTile(0);
    sendTile(576, 575, 1'b1, -1);
    finishTile("gaps");

    // early in_last on pixel 40
    pushTile(41, 1'b1);
    startTile(0);
    sendTile(41, 40, 1'b0, -1);
    finishTile("early_last");
    checkOutput("early_last_err_sticky", last_err_a, 1);

    // a new start clears last_err; then reset mid-tile after 50 pixels
    startTile(0);
    @(negedge clk);
    checkOutput("start_clears_last_err", last_err_a, 0);
    @(posedge clk); #1;
    exp_a.push_back('{addr: 12'h000, data: expWord(0, 576)});
    sendTile(50, -1, 1'b0, -1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("mid_reset");
    checkOutput("mid_reset_word0_written", exp_a.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    pushTile(576, 1'b0);
    startTile(0);
    sendTile(576, 575, 1'b0, -1);
    finishTile("after_reset");

    // start pulsed mid-tile and during DONE
    pushTile(576, 1'b0);
    startTile(0);
    sendTile(576, 575, 1'b0, 300);
    waitDone(0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    checkOutput("start_in_done_ignored", busy_a, 0);
    checkOutput("start_ignored_writes_seen", exp_a.size(), 0);
    @(posedge clk); #1;

    // final pixel without in_last
    pushTile(576, 1'b1);
    startTile(0);
    sendTile(576, -1, 1'b0, -1);
    finishTile("missing_last");
    checkOutput("missing_last_err", last_err_a, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
